// File: rtl/seq_alu.sv
// Registered ALU with single-cycle logic/arith/compare/shift ops and iterative
// shift-add multiply / restoring divide behind a start/busy/done handshake.
module seq_alu #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            sel,
  input  logic [DATA_WIDTH-1:0] in_0,
  input  logic [DATA_WIDTH-1:0] in_1,
  output logic [DATA_WIDTH-1:0] out,
  output logic [DATA_WIDTH-1:0] out_hi,
  output logic                  zero,
  output logic                  overflow,
  output logic                  div_by_zero,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned W   = DATA_WIDTH;
  localparam int unsigned SHW = $clog2(DATA_WIDTH);
  localparam int unsigned CW  = $clog2(DATA_WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  // Iteration engine: acc_hi = upper product / remainder, acc_lo = multiplier / quotient.
  logic [W-1:0]  acc_hi, acc_lo, opnd;
  logic [CW-1:0] cnt;
  logic          is_mul;

  logic [W-1:0]  acc_hi_nxt, acc_lo_nxt, opnd_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          is_mul_nxt;
  logic [W-1:0]  out_nxt, out_hi_nxt;
  logic          zero_nxt, overflow_nxt, div_by_zero_nxt, done_nxt;

  logic          iter_req, div_zero_req;
  logic [SHW-1:0] shamt;
  logic [W-1:0]  sum, diff, alu_res;
  logic          alu_ovf;

  logic [W:0]    mul_sum, div_rem_sh;
  logic [W-1:0]  div_sub, step_hi, step_lo;
  logic          div_ge;

  assign iter_req     = (sel == OP_MUL) || ((sel == OP_DIVU) && (in_1 != '0));
  assign div_zero_req = (sel == OP_DIVU) && (in_1 == '0);
  assign shamt        = in_1[SHW-1:0];
  assign sum          = in_0 + in_1;
  assign diff         = in_0 - in_1;
  assign busy         = (state == RUN);

  // Single-cycle result path
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (sel)
      OP_AND:  alu_res = in_0 & in_1;
      OP_OR:   alu_res = in_0 | in_1;
      OP_XOR:  alu_res = in_0 ^ in_1;
      OP_NOR:  alu_res = ~(in_0 | in_1);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (in_0[W-1] == in_1[W-1]) && (sum[W-1] != in_0[W-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (in_0[W-1] != in_1[W-1]) && (diff[W-1] != in_0[W-1]);
      end
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(in_0) < $signed(in_1))};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (in_0 < in_1)};
      OP_SLL:  alu_res = in_0 << shamt;
      OP_SRL:  alu_res = in_0 >> shamt;
      OP_SRA:  alu_res = W'($signed(in_0) >>> shamt);
      OP_DIVU: alu_res = '1;
      default: alu_res = '0;
    endcase
  end

  // One multiply or divide step
  always_comb begin
    mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_rem_sh = {acc_hi, acc_lo[W-1]};
    div_ge     = (div_rem_sh >= {1'b0, opnd});
    div_sub    = div_rem_sh[W-1:0] - opnd;
    if (is_mul) begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], acc_lo[W-1:1]};
    end else begin
      step_hi = div_ge ? div_sub : div_rem_sh[W-1:0];
      step_lo = {acc_lo[W-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && iter_req) state_nxt = RUN;
      RUN:  if (cnt == CW'(1))     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for result registers and the iteration engine
  always_comb begin
    out_nxt         = out;
    out_hi_nxt      = out_hi;
    zero_nxt        = zero;
    overflow_nxt    = overflow;
    div_by_zero_nxt = div_by_zero;
    done_nxt        = 1'b0;
    acc_hi_nxt      = acc_hi;
    acc_lo_nxt      = acc_lo;
    opnd_nxt        = opnd;
    cnt_nxt         = cnt;
    is_mul_nxt      = is_mul;
    case (state)
      IDLE: begin
        if (start && iter_req) begin
          is_mul_nxt = (sel == OP_MUL);
          acc_hi_nxt = '0;
          acc_lo_nxt = (sel == OP_MUL) ? in_1 : in_0;
          opnd_nxt   = (sel == OP_MUL) ? in_0 : in_1;
          cnt_nxt    = CW'(W);
        end else if (start) begin
          out_nxt         = alu_res;
          out_hi_nxt      = div_zero_req ? in_0 : '0;
          zero_nxt        = (alu_res == '0);
          overflow_nxt    = alu_ovf;
          div_by_zero_nxt = div_zero_req;
          done_nxt        = 1'b1;
        end
      end
      RUN: begin
        acc_hi_nxt = step_hi;
        acc_lo_nxt = step_lo;
        cnt_nxt    = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          out_nxt         = step_lo;
          out_hi_nxt      = step_hi;
          zero_nxt        = (step_lo == '0);
          overflow_nxt    = 1'b0;
          div_by_zero_nxt = 1'b0;
          done_nxt        = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out         <= '0;
      out_hi      <= '0;
      zero        <= 1'b1;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      cnt         <= '0;
      is_mul      <= 1'b0;
    end else begin
      out         <= out_nxt;
      out_hi      <= out_hi_nxt;
      zero        <= zero_nxt;
      overflow    <= overflow_nxt;
      div_by_zero <= div_by_zero_nxt;
      done        <= done_nxt;
      acc_hi      <= acc_hi_nxt;
      acc_lo      <= acc_lo_nxt;
      opnd        <= opnd_nxt;
      cnt         <= cnt_nxt;
      is_mul      <= is_mul_nxt;
    end
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU that extends the datapath's single-cycle ALU with iterative multiply and divide, signed/unsigned compare, shifts, and a start/busy/done handshake. Single-cycle ops complete one cycle after `start`. MUL and DIVU take DATA_WIDTH cycles through a shift-add / restoring-divide engine. The block sits in the execute stage of the multi-cycle core; the control unit stalls on `busy`.

## Interface
- `DATA_WIDTH`, default 32, operand/result width; legal values 8..64.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `sel`  in  4  operation select.
- `in_0`  in  DATA_WIDTH  operand A.
- `in_1`  in  DATA_WIDTH  operand B.
- `out`  out  DATA_WIDTH  result (low product word for MUL, quotient for DIVU).
- `out_hi`  out  DATA_WIDTH  high product word for MUL, remainder for DIVU, 0 otherwise.
- `zero`  out  1  `out`==0; registered with `out`.
- `overflow`  out  1  signed overflow for ADD/SUB; 0 for all other ops.
- `div_by_zero`  out  1  DIVU issued with `in_1`==0.
- `busy`  out  1  iterative op in progress.
- `done`  out  1  one-cycle pulse: results valid and updated this cycle.

## Operation
- sel codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB.
  - 0101 MUL (unsigned, 2·DATA_WIDTH product), 0110 SLT (signed), 0111 SLTU.
  - 1000 NOR, 1001 DIVU.
  - 1010 SLL, 1011 SRL, 1100 SRA.
  - Others: result 0, `zero`=1, `done` still pulses.
- Shift amount is the low ceil(log2 DATA_WIDTH) bits of `in_1`; the upper bits are ignored.
- SLT/SLTU return 1 or 0 in bit 0, with the upper bits zero.
- ADD/SUB wrap modulo 2^DATA_WIDTH. `overflow` = operand signs equal (ADD) or differ (SUB) and the result sign differs from `in_0`.
- FSM states: IDLE, RUN.
  - IDLE + `start` + single-cycle op: register results, pulse `done`, stay in IDLE.
  - IDLE + `start` + MUL: latch operands, load counter with DATA_WIDTH, clear the accumulator, go to RUN.
  - IDLE + `start` + DIVU with `in_1`≠0: same as MUL.
  - IDLE + `start` + DIVU with `in_1`==0: complete immediately as a single-cycle op. `out`=all ones, `out_hi`=`in_0`, `div_by_zero`=1.
  - RUN: one iteration per cycle; the counter decrements each cycle. The iteration with counter==1 writes the final results, pulses `done`, and returns to IDLE.
- MUL iteration: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half; then shift {carry, accumulator} right by 1.
- DIVU iteration (restoring):
  - Shift {remainder, quotient} left by 1.
  - Trial-subtract the divisor from the remainder.
  - If the result is non-negative, keep it and set quotient bit 0.
- Operands are latched at start. Changes on `in_0`, `in_1`, or `sel` while `busy` have no effect.
- `start` while `busy` is ignored and is not queued.
- `out`, `out_hi`, and the flags hold their last value until the next `done`.
- `div_by_zero` and `overflow` are rewritten on every `done`.
- Reset (any time, including mid-RUN) forces IDLE and aborts the operation:
  - `out`=0, `out_hi`=0, `zero`=1.
  - `overflow`=0, `div_by_zero`=0, `busy`=0, `done`=0.

## Timing
- Cycle k below means the cycle in which `start` is high and the block is in IDLE.
- Single-cycle op (including DIVU by zero): results and `done`=1 are visible in cycle k+1. `busy` stays 0.
- Back-to-back single-cycle ops are accepted every cycle, giving throughput of one per cycle.
- MUL/DIVU:
  - `busy`=1 in cycles k+1..k+DATA_WIDTH.
  - Results and `done`=1 appear in cycle k+DATA_WIDTH+1, with `busy`=0 in that cycle.
- A new `start` may be issued in the same cycle `done` is high.
- `done` is never high for two consecutive cycles for the same request.

## Test plan
- **Reset values:** assert `rst_n`=0 asynchronously mid-cycle → all outputs take their reset values immediately (`zero`=1, `out`=0, `busy`=0, `done`=0).
- **Single-cycle ops:**
  - ADD 0x7FFFFFFF+1 → `out`=0x80000000, `overflow`=1, `done` in k+1.
  - SUB 5-5 → `out`=0, `zero`=1.
  - SLT 0xFFFFFFFF,1 → 1; SLTU on the same operands → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
- **MUL:** 0xFFFFFFFF×0xFFFFFFFF → `out`=0x00000001, `out_hi`=0xFFFFFFFE. `busy` is high for exactly 32 cycles and `done` arrives in k+33. Toggling the operands and `start` while busy changes nothing.
- **DIVU:**
  - 100/7 → `out`=14, `out_hi`=2, latency 33.
  - 9/0 → `out`=0xFFFFFFFF, `out_hi`=9, `div_by_zero`=1, `done` in k+1.
- **Back-to-back and abort:**
  - Issue AND, OR, and XOR on consecutive cycles → three consecutive `done` pulses with the correct results.
  - Issue MUL, then deassert `rst_n` at busy cycle 10 → IDLE with reset outputs, and no `done` follows.
  - A subsequent DIVU completes normally.
- **Unknown sel:** sel=1111 → `out`=0, `zero`=1, `done` in k+1. Also repeat the MUL and DIVU cases at DATA_WIDTH=8: 255×255 → `out_hi`=0xFE, `out`=0x01, `done` in k+9.
